// File: rtl/ahci_dma_rd_prd_seq.sv
// Per-PRD read sequencer: programs the realignment FIFO and splits one descriptor into 4 KB-safe AXI read bursts (<= 1 burst / 2 cycles).
// ar_* held stable until ar_ready; optional qword/PRD counters when AHCI_DMA_RD_PRD_SEQ_STAT_EN is defined.
module ahci_dma_rd_prd_seq #(
  parameter int WCNT_BITS = 21,
  parameter int MAX_BURST = 16
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic                 prd_vld,
  output logic                 prd_rdy,
  input  logic [31:1]          prd_dba,
  input  logic [21:0]          prd_dbc,
  input  logic                 prd_last,
  input  logic                 abort,
  output logic [WCNT_BITS-1:0] fifo_wcnt,
  output logic [1:0]           fifo_woffs,
  output logic                 fifo_start,
  output logic                 fifo_last_prd,
  input  logic                 fifo_done,
  input  logic                 fifo_done_flush,
  output logic [28:0]          ar_addr,
  output logic [3:0]           ar_len,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic                 busy,
  output logic                 prd_done,
  output logic                 xfer_done,
  output logic                 aborted
`ifdef AHCI_DMA_RD_PRD_SEQ_STAT_EN
  ,
  output logic [31:0]          stat_qw,
  output logic [15:0]          stat_prd
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_DONE,
    S_WAIT_FLUSH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:1] r_dba;
  logic [21:0] r_dbc;
  logic        r_last;
  logic [28:0] r_qaddr;
  logic [32:0] r_qrem;
  logic        r_arv;
  logic [3:0]  r_ar_len;
  logic        r_abort_pend;
  logic        r_done_lat;
  logic        r_flush_lat;
  logic        r_prd_done;
  logic        r_xfer_done;
  logic        r_aborted;

  logic        w_accept;
  logic        w_hs;
  logic        w_abort_any;
  logic        w_take_abort;
  logic        w_arv_set;
  logic        w_prd_done_nxt;
  logic        w_xfer_done_nxt;
  logic        w_aborted_nxt;
  logic [32:0] w_end;
  logic [32:0] w_qrem_init;
  logic [9:0]  w_room;
  logic [4:0]  w_lim;
  logic [4:0]  w_n;
  logic [4:0]  w_nm1;

  assign prd_rdy       = (r_state == S_IDLE) && !abort && !hrst;
  assign fifo_start    = (r_state == S_LOAD);
  assign fifo_wcnt     = r_dbc[WCNT_BITS:1];
  assign fifo_woffs    = r_dba[2:1];
  assign fifo_last_prd = r_last;
  assign ar_addr       = r_qaddr;
  assign ar_len        = r_ar_len;
  assign ar_valid      = r_arv;
  assign busy          = (r_state != S_IDLE);
  assign prd_done      = r_prd_done;
  assign xfer_done     = r_xfer_done;
  assign aborted       = r_aborted;

  // End address is inclusive of the odd byte, so the qword span is end/8 - start/8 + 1.
  assign w_end       = {1'b0, r_dba, 1'b0} + {11'd0, r_dbc};
  assign w_qrem_init = (w_end >> 3) - {4'd0, r_dba[31:3]} + 33'd1;

  always_comb begin
    w_room = 10'd512 - {1'b0, r_qaddr[8:0]};
    w_lim  = (r_qrem > 33'(MAX_BURST)) ? 5'(MAX_BURST) : r_qrem[4:0];
    w_n    = ({5'd0, w_lim} > w_room) ? w_room[4:0] : w_lim;
    w_nm1  = w_n - 5'd1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_take_abort    = 1'b0;
    w_arv_set       = 1'b0;
    w_prd_done_nxt  = 1'b0;
    w_xfer_done_nxt = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_hs            = r_arv && ar_ready;
    w_abort_any     = abort || r_abort_pend;
    unique case (r_state)
      S_IDLE: begin
        if (abort) begin
          w_aborted_nxt = 1'b1;
        end else if (prd_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_abort_any) w_take_abort = 1'b1;
        else             w_state_nxt  = S_ISSUE;
      end
      S_ISSUE: begin
        // A presented address is never withdrawn: abort waits for the handshake.
        if (!r_arv) begin
          if (w_abort_any) w_take_abort = 1'b1;
          else             w_arv_set    = 1'b1;
        end else if (w_hs) begin
          if (w_abort_any)                      w_take_abort = 1'b1;
          else if (r_qrem == {28'd0, w_n})      w_state_nxt  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_abort_any) begin
          w_take_abort = 1'b1;
        end else if (fifo_done || r_done_lat) begin
          w_prd_done_nxt = 1'b1;
          w_state_nxt    = r_last ? S_WAIT_FLUSH : S_IDLE;
        end
      end
      S_WAIT_FLUSH: begin
        if (w_abort_any) begin
          w_take_abort = 1'b1;
        end else if (fifo_done_flush || r_flush_lat) begin
          w_xfer_done_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_take_abort) begin
      w_state_nxt   = S_IDLE;
      w_aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state      <= S_IDLE;
      r_dba        <= '0;
      r_dbc        <= '0;
      r_last       <= 1'b0;
      r_qaddr      <= '0;
      r_qrem       <= '0;
      r_arv        <= 1'b0;
      r_ar_len     <= '0;
      r_abort_pend <= 1'b0;
      r_done_lat   <= 1'b0;
      r_flush_lat  <= 1'b0;
      r_prd_done   <= 1'b0;
      r_xfer_done  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dba  <= prd_dba;
        r_dbc  <= prd_dbc | 22'd1;
        r_last <= prd_last;
      end
      if (r_state == S_LOAD) begin
        r_qaddr <= r_dba[31:3];
        r_qrem  <= w_qrem_init;
      end
      if (w_arv_set) begin
        r_arv    <= 1'b1;
        r_ar_len <= w_nm1[3:0];
      end else if (w_hs) begin
        r_arv   <= 1'b0;
        r_qaddr <= r_qaddr + {24'd0, w_n};
        r_qrem  <= r_qrem - {28'd0, w_n};
      end
      r_abort_pend <= (r_state != S_IDLE) && !w_take_abort && (r_abort_pend || abort);
      // Early completions are remembered until the state that consumes them.
      r_done_lat   <= (r_state inside {S_LOAD, S_ISSUE}) && !w_take_abort &&
                      (r_done_lat || fifo_done);
      r_flush_lat  <= (r_state inside {S_LOAD, S_ISSUE, S_WAIT_DONE}) && !w_take_abort &&
                      (r_flush_lat || fifo_done_flush);
      r_prd_done   <= w_prd_done_nxt;
      r_xfer_done  <= w_xfer_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

`ifdef AHCI_DMA_RD_PRD_SEQ_STAT_EN
  logic [31:0] r_stat_qw;
  logic [15:0] r_stat_prd;
  logic        r_cmd_end;

  assign stat_qw  = r_stat_qw;
  assign stat_prd = r_stat_prd;

  // Counters keep the finished command's totals visible until the next command starts.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_stat_qw  <= '0;
      r_stat_prd <= '0;
      r_cmd_end  <= 1'b0;
    end else begin
      if (w_accept && r_cmd_end) begin
        r_stat_qw  <= '0;
        r_stat_prd <= '0;
        r_cmd_end  <= 1'b0;
      end else begin
        if (w_hs)           r_stat_qw  <= r_stat_qw + {27'd0, w_n};
        if (w_prd_done_nxt) r_stat_prd <= r_stat_prd + 16'd1;
        if (w_xfer_done_nxt || w_aborted_nxt) r_cmd_end <= 1'b1;
      end
    end
  end
`endif

endmodule
